// File: rtl/clock_ctrl_pkg.sv
// Shared clock-edit types: FSM states and field-select codes.
// Imported by the edit controller and by timecounter users.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    EDIT_HH,
    EDIT_MM,
    EDIT_SS
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_SS   = 2'b01;
  localparam logic [1:0] SEL_MM   = 2'b10;
  localparam logic [1:0] SEL_HH   = 2'b11;

  function automatic logic [1:0] sel_of(state_t s);
    sel_of = SEL_NONE;
    unique case (s)
      RUN:     sel_of = SEL_NONE;
      EDIT_HH: sel_of = SEL_HH;
      EDIT_MM: sel_of = SEL_MM;
      EDIT_SS: sel_of = SEL_SS;
    endcase
  endfunction

endpackage

// File: rtl/key_autorepeat.sv
// One key: rising-edge pulse plus delay/rate auto-repeat.
// The other key's level blocks this one and clears its counter.
module key_autorepeat #(
  parameter int DELAY = 500,
  parameter int RATE  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key,
  input  logic other,
  input  logic en,
  input  logic hold_off,
  output logic pulse
);

  localparam int MX = (DELAY > RATE) ? DELAY : RATE;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] DLY_M1 = CW'(DELAY - 1);
  localparam logic [CW-1:0] RAT_M1 = CW'(RATE - 1);
  localparam logic [CW-1:0] CMAX   = {CW{1'b1}};

  logic          key_q;
  logic          rep;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          go;
  logic          fire;

  assign rise = key & ~key_q;
  assign go   = en & key & ~other;

  always_comb begin
    fire = 1'b0;
    if (go) begin
      if (rise)
        fire = 1'b1;
      else if (tick)
        fire = rep ? (cnt == RAT_M1)
                   : (cnt == DLY_M1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= 1'b0;
      rep   <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      key_q <= key;
      pulse <= fire & ~hold_off;
      if (!go || hold_off || rise) begin
        cnt <= '0;
        rep <= 1'b0;
      end else if (tick) begin
        if (fire) begin
          cnt <= '0;
          rep <= 1'b1;
        end else if (cnt != CMAX) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clock_edit_ctrl.sv
// Clock-setting controller: mode FSM, up/down keys with
// auto-repeat, inactivity timeout and field blinking.
module clock_edit_ctrl #(
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int TIMEOUT_S       = 30,
  parameter int BLINK_MS        = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick1Hz,
  input  logic       tick1kHz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic       freeze,
  output logic [1:0] sel,
  output logic       inc,
  output logic       dec,
  output logic       blink_on
);

  import clock_ctrl_pkg::*;

  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [TW-1:0] TO_M1 = TW'(TIMEOUT_S - 1);
  localparam logic [BW-1:0] BL_M1 = BW'(BLINK_MS - 1);

  state_t        state;
  state_t        state_nx;
  logic          edit;
  logic          act;
  logic          tmo;
  logic          chg;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] bl_cnt;
  logic          bl_ph;

  assign edit = (state != RUN);
  assign act  = btn_mode | btn_up | btn_dn;
  assign tmo  = edit & tick1Hz & ~act
              & (to_cnt == TO_M1);

  always_comb begin
    state_nx = state;
    if (btn_mode) begin
      unique case (state)
        RUN:     state_nx = EDIT_HH;
        EDIT_HH: state_nx = EDIT_MM;
        EDIT_MM: state_nx = EDIT_SS;
        EDIT_SS: state_nx = RUN;
      endcase
    end else if (tmo) begin
      state_nx = RUN;
    end
  end

  assign chg = (state_nx != state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze <= 1'b0;
      sel    <= SEL_NONE;
    end else begin
      freeze <= (state_nx != RUN);
      sel    <= sel_of(state_nx);
    end
  end

  // held keys count as activity, so a hold never times out
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (!edit || act || chg)
      to_cnt <= '0;
    else if (tick1Hz && to_cnt != TO_M1)
      to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bl_cnt <= '0;
      bl_ph  <= 1'b1;
    end else if (!edit || chg) begin
      bl_cnt <= '0;
      bl_ph  <= 1'b1;
    end else if (tick1kHz) begin
      if (bl_cnt == BL_M1) begin
        bl_cnt <= '0;
        bl_ph  <= ~bl_ph;
      end else begin
        bl_cnt <= bl_cnt + 1'b1;
      end
    end
  end

  assign blink_on = ~edit | btn_up | btn_dn | bl_ph;

  key_autorepeat #(
    .DELAY (REPEAT_DELAY_MS),
    .RATE  (REPEAT_RATE_MS)
  ) u_up (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick1kHz),
    .key      (btn_up),
    .other    (btn_dn),
    .en       (edit),
    .hold_off (chg),
    .pulse    (inc)
  );

  key_autorepeat #(
    .DELAY (REPEAT_DELAY_MS),
    .RATE  (REPEAT_RATE_MS)
  ) u_dn (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick1kHz),
    .key      (btn_dn),
    .other    (btn_up),
    .en       (edit),
    .hold_off (chg),
    .pulse    (dec)
  );

endmodule

// File: tb/tb_clock_edit_ctrl.sv
// Scoreboard bench for clock_edit_ctrl: expected pulses and
// sel/freeze changes are queued and checked by a monitor.
module tb_clock_edit_ctrl;

  import clock_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick1Hz;
  logic       tick1kHz;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_dn;
  logic       freeze;
  logic [1:0] sel;
  logic       inc;
  logic       dec;
  logic       blink_on;

  int cyc    = 0;
  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic is_inc;
    int   cyc;
  } pev_t;

  typedef struct {
    logic [1:0] sel;
    logic       frz;
    int         cyc;
  } sev_t;

  pev_t pq[$];
  sev_t sq[$];

  clock_edit_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick1Hz  (tick1Hz),
    .tick1kHz (tick1kHz),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .freeze   (freeze),
    .sel      (sel),
    .inc      (inc),
    .dec      (dec),
    .blink_on (blink_on)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] b);
    checks++;
    if (a !== b) begin
      errs++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)",
               nm, a, b, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_p(input logic is_inc,
                        input int at);
    pev_t e;
    e.is_inc = is_inc;
    e.cyc    = at;
    pq.push_back(e);
  endtask

  task automatic push_s(input logic [1:0] s,
                        input logic f,
                        input int at);
    sev_t e;
    e.sel = s;
    e.frz = f;
    e.cyc = at;
    sq.push_back(e);
  endtask

  task automatic tk();
    tick1kHz = 1'b1;
    step();
    tick1kHz = 1'b0;
    step();
  endtask

  task automatic hz();
    tick1Hz = 1'b1;
    step();
    tick1Hz = 1'b0;
    step();
  endtask

  task automatic mode(input logic [1:0] s,
                      input logic f);
    push_s(s, f, cyc + 1);
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
  endtask

  // monitor: pops an expectation for every pulse or sel change
  initial begin
    logic [1:0] psel;
    logic       pfrz;
    pev_t       pe;
    sev_t       se;
    psel = SEL_NONE;
    pfrz = 1'b0;
    forever begin
      @(negedge clk);
      if (inc || dec) begin
        if (inc && dec)
          chk("inc_dec_same_cycle", 32'(1), 32'(0));
        if (pq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_pulse: inc=%0b dec=%0b cyc %0d, required none",
                   inc, dec, cyc);
        end else begin
          pe = pq.pop_front();
          chk("pulse_kind", 32'(inc), 32'(pe.is_inc));
          chk("pulse_cycle", 32'(cyc), 32'(pe.cyc));
        end
      end
      if (sel !== psel || freeze !== pfrz) begin
        if (sq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_sel: sel=%0b freeze=%0b cyc %0d, required none",
                   sel, freeze, cyc);
        end else begin
          se = sq.pop_front();
          chk("sel_value", 32'(sel), 32'(se.sel));
          chk("freeze_value", 32'(freeze), 32'(se.frz));
          chk("sel_cycle", 32'(cyc), 32'(se.cyc));
        end
        psel = sel;
        pfrz = freeze;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rep_at[4];
    rep_at = '{500, 600, 700, 800};
    rst      = 1'b1;
    tick1Hz  = 1'b0;
    tick1kHz = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_dn   = 1'b0;
    step();
    step();
    step();
    chk("rst_freeze", 32'(freeze), 32'(0));
    chk("rst_sel", 32'(sel), 32'(SEL_NONE));
    chk("rst_inc", 32'(inc), 32'(0));
    chk("rst_dec", 32'(dec), 32'(0));
    chk("rst_blink", 32'(blink_on), 32'(1));
    rst = 1'b0;
    step();

    // full mode cycle
    mode(SEL_HH, 1'b1);
    mode(SEL_MM, 1'b1);
    mode(SEL_SS, 1'b1);
    mode(SEL_NONE, 1'b0);

    // blink in EDIT_HH, then a down press
    mode(SEL_HH, 1'b1);
    chk("blink_entry", 32'(blink_on), 32'(1));
    for (int k = 0; k < 249; k++) tk();
    chk("blink_249", 32'(blink_on), 32'(1));
    tk();
    chk("blink_250", 32'(blink_on), 32'(0));
    push_p(1'b0, cyc + 1);
    btn_dn = 1'b1;
    step();
    chk("blink_key", 32'(blink_on), 32'(1));
    btn_dn = 1'b0;
    step();

    // timeout restarted by a press at tick 29
    for (int k = 0; k < 29; k++) hz();
    push_p(1'b1, cyc + 1);
    btn_up = 1'b1;
    step();
    btn_up = 1'b0;
    step();
    for (int k = 0; k < 29; k++) hz();
    push_s(SEL_NONE, 1'b0, cyc + 1);
    hz();

    // mode wins over a coincident up edge
    mode(SEL_HH, 1'b1);
    push_s(SEL_MM, 1'b1, cyc + 1);
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
    step();
    btn_up = 1'b0;
    step();

    // hold in EDIT_MM for 800 ticks
    push_p(1'b1, cyc + 1);
    btn_up = 1'b1;
    step();
    for (int k = 1; k <= 800; k++) begin
      for (int j = 0; j < 4; j++)
        if (rep_at[j] == k) push_p(1'b1, cyc + 1);
      tk();
    end
    btn_up = 1'b0;
    step();

    // both keys in EDIT_SS
    mode(SEL_SS, 1'b1);
    btn_up = 1'b1;
    btn_dn = 1'b1;
    for (int k = 0; k < 1000; k++) tk();
    btn_dn = 1'b0;
    step();
    step();
    btn_up = 1'b0;
    step();

    // no inc in RUN
    mode(SEL_NONE, 1'b0);
    btn_up = 1'b1;
    step();
    step();
    chk("run_blink", 32'(blink_on), 32'(1));
    btn_up = 1'b0;
    step();

    // reset in the middle of a repeat
    mode(SEL_HH, 1'b1);
    push_p(1'b1, cyc + 1);
    btn_up = 1'b1;
    step();
    for (int k = 1; k <= 550; k++) begin
      if (k == 500) push_p(1'b1, cyc + 1);
      tk();
    end
    push_s(SEL_NONE, 1'b0, cyc);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 300; k++) tk();
    btn_up = 1'b0;
    step();
    chk("post_rst_blink", 32'(blink_on), 32'(1));

    for (int k = 0; k < 5; k++) step();
    chk("pulse_queue_empty", 32'(pq.size()), 32'(0));
    chk("sel_queue_empty", 32'(sq.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
